// File: rtl/pr_update_queue_pkg.sv
// Shared types and defaults for the predictor-update queue.
package pr_update_queue_pkg;

  localparam int PRQ_DEPTH_DEF     = 4;
  localparam int PRQ_CNT_WIDTH_DEF = 8;
  localparam int PRQ_PC_W          = 32;
  localparam int PRQ_TICKET_W      = 4;
  localparam int PRQ_RAT_ID_W      = 5;

  typedef struct packed {
    logic                    valid_jump;
    logic                    jump_taken;
    logic                    is_comp;
    logic [PRQ_PC_W-1:0]     orig_pc;
    logic [PRQ_PC_W-1:0]     jump_address;
    logic [PRQ_TICKET_W-1:0] ticket;
    logic [PRQ_RAT_ID_W-1:0] rat_id;
  } predictor_update;

endpackage

// File: rtl/pr_update_queue_if.sv
// Resolver-to-tables update bus: enqueue input plus the valid/ready drain side.
interface pr_update_queue_if;
  import pr_update_queue_pkg::*;

  predictor_update pr_in;
  predictor_update pr_out;
  logic            pr_out_valid;
  logic            pr_out_ready;

  modport master (output pr_in, output pr_out_ready, input pr_out, input pr_out_valid);
  modport slave  (input pr_in, input pr_out_ready, output pr_out, output pr_out_valid);
endinterface

// File: rtl/pr_update_queue_storage.sv
// DEPTH-entry register array, one write port and one asynchronous read port.
module prq_storage
  import pr_update_queue_pkg::*;
#(
  parameter int DEPTH = PRQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  predictor_update          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output predictor_update          rdata
);

  predictor_update mem_q [DEPTH];

  // Payload is never reset; occupancy in the top decides what is meaningful.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pr_update_queue.sv
// Elastic FIFO of predictor updates; drops on overflow instead of stalling.
// Optional PRQ_BYPASS_EN: an empty queue forwards pr_in to pr_out in the same cycle.
module pr_update_queue
  import pr_update_queue_pkg::*;
#(
  parameter int DEPTH     = PRQ_DEPTH_DEF,
  parameter int CNT_WIDTH = PRQ_CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pr_update_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  predictor_update      rd_data;
  logic                 enq_req, byp, deq, deq_mem, wr_en;

  prq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (tail_q),
    .wdata (bus.pr_in),
    .raddr (head_q),
    .rdata (rd_data)
  );

  always_comb begin
    full    = (occ_q == OCC_W'(DEPTH));
    empty   = (occ_q == '0);
    enq_req = bus.pr_in.valid_jump & ~flush;
`ifdef PRQ_BYPASS_EN
    byp     = empty & enq_req;
`else
    byp     = 1'b0;
`endif
    bus.pr_out_valid = ~empty | byp;
    bus.pr_out       = byp ? bus.pr_in : (empty ? '0 : rd_data);
    deq      = bus.pr_out_valid & bus.pr_out_ready;
    deq_mem  = deq & ~empty;
    // A bypassed entry consumed this cycle never touches storage.
    wr_en    = enq_req & (~full | deq) & ~(byp & deq);
    overflow = enq_req & full & ~deq;

    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (deq_mem) head_d = head_q + PTR_W'(1);
      if (wr_en)   tail_d = tail_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(wr_en) - OCC_W'(deq_mem);
    end

    drop_d = drop_q;
    if (overflow && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  assign occupancy  = occ_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pr_update_queue.sv
// Directed bench for pr_update_queue: vector table plus multi-cycle corner sequences.
module tb_pr_update_queue;
  import pr_update_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] occupancy;
  logic       full, empty, overflow;
  logic [7:0] drop_count;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         exp_drop;

  pr_update_queue_if bus ();

  pr_update_queue #(.DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus.slave),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        vj;
    logic        rdy;
    logic [31:0] pc;
    logic        vld;
    logic [31:0] opc;
    int          occ;
    logic        ovf;
    int          drop;
  } vec_t;

  localparam int NV = 36;
  vec_t tbl [NV];

  function automatic predictor_update mk(input logic [31:0] pc);
    predictor_update u;
    u.valid_jump   = 1'b1;
    u.jump_taken   = pc[2];
    u.is_comp      = pc[3];
    u.orig_pc      = pc;
    u.jump_address = pc + 32'h80;
    u.ticket       = pc[5:2];
    u.rat_id       = pc[6:2];
    return u;
  endfunction

  function automatic vec_t v(input logic fl, input logic vj, input logic rdy, input logic [31:0] pc,
                             input logic vld, input logic [31:0] opc, input int occ,
                             input logic ovf, input int drop);
    vec_t r;
    r.fl = fl; r.vj = vj; r.rdy = rdy; r.pc = pc;
    r.vld = vld; r.opc = opc; r.occ = occ; r.ovf = ovf; r.drop = drop;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic fl, input logic vj, input logic rdy, input logic [31:0] pc);
    @(negedge clk);
    flush            = fl;
    bus.pr_in        = vj ? mk(pc) : '0;
    bus.pr_out_ready = rdy;
    #1;
  endtask

  task automatic chk_out(input string nm, input logic vld, input logic [31:0] opc);
    predictor_update e;
    e = vld ? mk(opc) : '0;
    chk({nm, "_vld"}, 128'(bus.pr_out_valid), 128'(vld));
    chk({nm, "_pr_out"}, 128'(bus.pr_out), 128'(e));
  endtask

  task automatic chk_state(input string nm, input int occ, input logic ovf, input int drop);
    chk({nm, "_occ"}, 128'(occupancy), 128'(occ));
    chk({nm, "_full"}, 128'(full), 128'(occ == 4));
    chk({nm, "_empty"}, 128'(empty), 128'(occ == 0));
    chk({nm, "_ovf"}, 128'(overflow), 128'(ovf));
    chk({nm, "_drop"}, 128'(drop_count), 128'(drop));
  endtask

  initial begin
    // test 1: single jal, ready high
    tbl[0]  = v(0,1,1,'h100, 0,'h000, 0,0,0);
    tbl[1]  = v(0,0,1,'h000, 1,'h100, 1,0,0);
    tbl[2]  = v(0,0,0,'h000, 0,'h000, 0,0,0);
    // test 2: five enqueues into a stalled queue, then drain
    tbl[3]  = v(0,1,0,'h104, 0,'h000, 0,0,0);
    tbl[4]  = v(0,1,0,'h108, 1,'h104, 1,0,0);
    tbl[5]  = v(0,1,0,'h10C, 1,'h104, 2,0,0);
    tbl[6]  = v(0,1,0,'h110, 1,'h104, 3,0,0);
    tbl[7]  = v(0,1,0,'h114, 1,'h104, 4,1,0);
    tbl[8]  = v(0,0,0,'h000, 1,'h104, 4,0,1);
    tbl[9]  = v(0,0,1,'h000, 1,'h104, 4,0,1);
    tbl[10] = v(0,0,1,'h000, 1,'h108, 3,0,1);
    tbl[11] = v(0,0,1,'h000, 1,'h10C, 2,0,1);
    tbl[12] = v(0,0,1,'h000, 1,'h110, 1,0,1);
    tbl[13] = v(0,0,0,'h000, 0,'h000, 0,0,1);
    // test 3: full with simultaneous enq+deq, pointers wrap 3 -> 0
    tbl[14] = v(0,1,0,'h120, 0,'h000, 0,0,1);
    tbl[15] = v(0,1,0,'h124, 1,'h120, 1,0,1);
    tbl[16] = v(0,1,0,'h128, 1,'h120, 2,0,1);
    tbl[17] = v(0,1,0,'h12C, 1,'h120, 3,0,1);
    tbl[18] = v(0,1,1,'h130, 1,'h120, 4,0,1);
    tbl[19] = v(0,1,1,'h134, 1,'h124, 4,0,1);
    tbl[20] = v(0,0,1,'h000, 1,'h128, 4,0,1);
    tbl[21] = v(0,0,1,'h000, 1,'h12C, 3,0,1);
    tbl[22] = v(0,0,1,'h000, 1,'h130, 2,0,1);
    tbl[23] = v(0,0,1,'h000, 1,'h134, 1,0,1);
    tbl[24] = v(0,0,0,'h000, 0,'h000, 0,0,1);
    // test 4: flush with enqueue at occupancy 3, then at full
    tbl[25] = v(0,1,0,'h140, 0,'h000, 0,0,1);
    tbl[26] = v(0,1,0,'h144, 1,'h140, 1,0,1);
    tbl[27] = v(0,1,0,'h148, 1,'h140, 2,0,1);
    tbl[28] = v(1,1,0,'h14C, 1,'h140, 3,0,1);
    tbl[29] = v(0,0,0,'h000, 0,'h000, 0,0,1);
    tbl[30] = v(0,1,0,'h150, 0,'h000, 0,0,1);
    tbl[31] = v(0,1,0,'h154, 1,'h150, 1,0,1);
    tbl[32] = v(0,1,0,'h158, 1,'h150, 2,0,1);
    tbl[33] = v(0,1,0,'h15C, 1,'h150, 3,0,1);
    tbl[34] = v(1,1,0,'h160, 1,'h150, 4,0,1);
    tbl[35] = v(0,0,0,'h000, 0,'h000, 0,0,1);

    // reset state
    rst = 1'b1; flush = 1'b0; bus.pr_in = '0; bus.pr_out_ready = 1'b0;
    #1;
    chk_out("rst", 1'b0, 32'h0);
    chk_state("rst", 0, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifndef PRQ_BYPASS_EN
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].fl, tbl[i].vj, tbl[i].rdy, tbl[i].pc);
      chk_out($sformatf("r%0d", i), tbl[i].vld, tbl[i].opc);
      chk_state($sformatf("r%0d", i), tbl[i].occ, tbl[i].ovf, tbl[i].drop);
    end
    exp_drop = 1;
`else
    // test 1 with bypass: same-cycle valid and no storage use when consumed
    step(0, 1, 1, 'h100); chk_out("byp_a", 1'b1, 'h100); chk_state("byp_a", 0, 1'b0, 0);
    step(0, 0, 1, 'h000); chk_out("byp_b", 1'b0, 'h000); chk_state("byp_b", 0, 1'b0, 0);
    step(0, 1, 0, 'h104); chk_out("byp_c", 1'b1, 'h104); chk_state("byp_c", 0, 1'b0, 0);
    step(0, 0, 0, 'h000); chk_out("byp_d", 1'b1, 'h104); chk_state("byp_d", 1, 1'b0, 0);
    step(0, 0, 1, 'h000); chk_out("byp_e", 1'b1, 'h104); chk_state("byp_e", 1, 1'b0, 0);
    step(0, 0, 0, 'h000); chk_out("byp_f", 1'b0, 'h000); chk_state("byp_f", 0, 1'b0, 0);
    exp_drop = 0;
`endif

    // test 5: head held stable under backpressure, then drop counter saturation
    step(1, 0, 0, 'h000);
    step(0, 1, 0, 'h170);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 'h000);
      chk_out($sformatf("hold%0d", i), 1'b1, 'h170);
    end
    step(0, 1, 0, 'h174);
    step(0, 1, 0, 'h178);
    step(0, 1, 0, 'h17C);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 0, 'h180);
      chk($sformatf("sat%0d_drop", i), 128'(drop_count),
          128'((exp_drop + i > 255) ? 255 : exp_drop + i));
      if (i == 0 || i == 299) chk($sformatf("sat%0d_ovf", i), 128'(overflow), 128'(1));
    end
    step(0, 0, 0, 'h000);
    chk_out("sat_head", 1'b1, 'h170);
    chk_state("sat_end", 4, 1'b0, 255);
    step(1, 1, 0, 'h190);
    chk("flush_full_ovf", 128'(overflow), 128'(0));
    step(0, 0, 0, 'h000);
    chk_state("post_flush", 0, 1'b0, 255);

    // test 6: async reset in the middle of a drain
    step(0, 1, 0, 'h1A0);
    step(0, 1, 0, 'h1A4);
    step(0, 0, 1, 'h000);
    chk_out("mid_drain", 1'b1, 'h1A0);
    chk_state("mid_drain", 2, 1'b0, 255);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 'h000);
    chk_state("async_rst", 0, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 'h000); chk_out("post_rst_a", 1'b0, 'h000); chk_state("post_rst_a", 0, 1'b0, 0);
    step(0, 0, 1, 'h000); chk_out("post_rst_b", 1'b0, 'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
